prog_sequencer: RTL

Parametrised program sequencer for the multi-problem processor core. It replaces the fixed-problem program counter with a programmable per-program jump table. It also adds a runtime program select, a stall input, halt-opcode detection, a start/done handshake and a run-cycle counter. It sits between the instruction ROM and the control decoder: it drives the fetch address and takes branch requests back from the decoder.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_jump_table.sv | 48 ++++
 rtl/prog_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and default widths for the program sequencer.
package seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_PC_W      = 8;
    localparam int unsigned DEF_INSTR_W   = 9;
    localparam int unsigned DEF_NUM_PROGS = 4;
    localparam int unsigned DEF_JT_DEPTH  = 16;
    localparam int unsigned DEF_CYC_W     = 16;

    localparam logic [DEF_INSTR_W-1:0] DEF_HALT_INSTR = 9'h1FF;

endpackage

// File: rtl/seq_jump_table.sv
// Per-program jump table: one write port, two combinational read ports.
//   clk, reset            : clock, synchronous active-high clear of every entry
//   we/wr_prog/wr_idx/wr_data : write strobe, slot, entry, target address
//   ep_prog -> ep_data    : entry-point (index 0) read of a program
//   br_prog/br_idx -> br_data : branch-target read
module seq_jump_table
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned NUM_PROGS = DEF_NUM_PROGS,
    parameter int unsigned JT_DEPTH  = DEF_JT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [$clog2(NUM_PROGS)-1:0]  wr_prog,
    input  logic [$clog2(JT_DEPTH)-1:0]   wr_idx,
    input  logic [PC_W-1:0]               wr_data,
    input  logic [$clog2(NUM_PROGS)-1:0]  ep_prog,
    output logic [PC_W-1:0]               ep_data,
    input  logic [$clog2(NUM_PROGS)-1:0]  br_prog,
    input  logic [$clog2(JT_DEPTH)-1:0]   br_idx,
    output logic [PC_W-1:0]               br_data
);

    localparam int unsigned PROG_W  = $clog2(NUM_PROGS);
    localparam int unsigned IDX_W   = $clog2(JT_DEPTH);
    localparam int unsigned ADDR_W  = PROG_W + IDX_W;
    localparam int unsigned ENTRIES = NUM_PROGS * JT_DEPTH;

    logic [PC_W-1:0] mem [ENTRIES];

    // Reset wins over a same-cycle write, so that write is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (we) begin
            mem[{wr_prog, wr_idx}] <= wr_data;
        end
    end

    // Reads see the pre-edge contents (old value on same-entry write)
    assign ep_data = mem[{ep_prog, IDX_W'(0)}];
    assign br_data = mem[{br_prog, br_idx}];

endmodule

// File: rtl/prog_sequencer.sv
// Programmable program sequencer: drives the fetch pc from a per-program
// jump table, with start/done handshake, stall, halt detection and a
// saturating run-cycle counter.
//   clk, reset        : clock, synchronous active-high reset
//   start, prog_sel   : load request (level) / program select
//   instr             : ROM word at pc
//   stall             : hold pc this cycle
//   branch_en/idx     : branch via jump-table entry of the active program
//   jt_we/prog/idx/data : jump-table write port
//   pc, active_prog, busy, done, cycle_count : registered status outputs
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned INSTR_W   = DEF_INSTR_W,
    parameter int unsigned NUM_PROGS = DEF_NUM_PROGS,
    parameter int unsigned JT_DEPTH  = DEF_JT_DEPTH,
    parameter int unsigned CYC_W     = DEF_CYC_W,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(DEF_HALT_INSTR)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(NUM_PROGS)-1:0]  prog_sel,
    input  logic [INSTR_W-1:0]            instr,
    input  logic                          stall,
    input  logic                          branch_en,
    input  logic [$clog2(JT_DEPTH)-1:0]   branch_idx,
    input  logic                          jt_we,
    input  logic [$clog2(NUM_PROGS)-1:0]  jt_prog,
    input  logic [$clog2(JT_DEPTH)-1:0]   jt_idx,
    input  logic [PC_W-1:0]               jt_data,
    output logic [PC_W-1:0]               pc,
    output logic [$clog2(NUM_PROGS)-1:0]  active_prog,
    output logic                          busy,
    output logic                          done,
    output logic [CYC_W-1:0]              cycle_count
);

    localparam int unsigned PROG_W = $clog2(NUM_PROGS);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_d;
    logic [PROG_W-1:0]   active_prog_d;
    logic [CYC_W-1:0]    cycle_count_d;
    logic                busy_d, done_d;
    logic                load;
    logic [PC_W-1:0]     ep_data, br_data;

    seq_jump_table #(
        .PC_W      (PC_W),
        .NUM_PROGS (NUM_PROGS),
        .JT_DEPTH  (JT_DEPTH)
    ) u_jt (
        .clk     (clk),
        .reset   (reset),
        .we      (jt_we),
        .wr_prog (jt_prog),
        .wr_idx  (jt_idx),
        .wr_data (jt_data),
        .ep_prog (prog_sel),
        .ep_data (ep_data),
        .br_prog (active_prog),
        .br_idx  (branch_idx),
        .br_data (br_data)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        active_prog_d = active_prog;
        cycle_count_d = cycle_count;
        load          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    load    = 1'b1;
                end
            end
            LOAD: begin
                load = 1'b1;
                if (!start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Every RUN cycle counts, including stalls and the halt cycle
                if (cycle_count != '1) begin
                    cycle_count_d = cycle_count + 1'b1;
                end
                if (start) begin
                    state_d = LOAD;
                    load    = 1'b1;
                end else if (instr == HALT_INSTR) begin
                    state_d = DONE;
                end else if (!stall) begin
                    if (branch_en) begin
                        pc_d = br_data;
                    end else begin
                        pc_d = pc + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any entry into (or stay in) LOAD latches the selected program
        if (load) begin
            active_prog_d = prog_sel;
            pc_d          = ep_data;
            cycle_count_d = '0;
        end

        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            active_prog <= '0;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            active_prog <= active_prog_d;
            cycle_count <= cycle_count_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule
